// File: rtl/upsp_arb_pkg.sv
// Shared types, default geometry and configuration helpers for the upsampler output arbiter.
package upsp_arb_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StFlush} arb_state_e;

   // Bit width for a counter spanning n values, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic bit cfg_ok(input int unsigned n_parallel, input int unsigned img_width,
                                 input int unsigned pix_per_beat);
      return (n_parallel >= 1) && (pix_per_beat >= 1) && ((img_width % pix_per_beat) == 0);
   endfunction

   localparam int unsigned DEF_N_PARALLEL     = 4;
   localparam int unsigned DEF_DST_IMG_WIDTH  = 3840;
   localparam int unsigned DEF_DST_IMG_HEIGHT = 2160;
   localparam int unsigned DEF_PIX_PER_BEAT   = 1;

   localparam int unsigned BEATS = DEF_DST_IMG_WIDTH / DEF_PIX_PER_BEAT;
   localparam int unsigned COL_W = cnt_width(BEATS);
   localparam int unsigned ROW_W = cnt_width(DEF_DST_IMG_HEIGHT);
   localparam int unsigned PTR_W = cnt_width(DEF_N_PARALLEL);

endpackage

// File: rtl/upsp_arb_out_slice.sv
// Single-entry AXI4-Stream output register carrying data plus tlast/tuser framing.
module upsp_arb_out_slice
   import upsp_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  load_last,
   input  logic                  load_user,
   input  logic                  tready,
   output logic                  tvalid,
   output logic [DATA_WIDTH-1:0] tdata,
   output logic                  tlast,
   output logic                  tuser,
   output logic                  out_free
);

   logic                  valid_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  last_q;
   logic                  user_q;

   // A load is only issued when out_free, so a held beat is never overwritten.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
         user_q  <= 1'b0;
      end else if (load) begin
         valid_q <= 1'b1;
         data_q  <= load_data;
         last_q  <= load_last;
         user_q  <= load_user;
      end else if (tready) begin
         valid_q <= 1'b0;
      end
   end

   assign out_free = !valid_q || tready;
   assign tvalid   = valid_q;
   assign tdata    = data_q;
   assign tlast    = last_q;
   assign tuser    = user_q;

endmodule

// File: rtl/upsp_output_arbiter.sv
// Round-robin collector of PE output words into one framed AXI4-Stream master.
// Optional stall_cycles counter enabled by defining UPSP_ARB_STALL_CNT_EN.
module upsp_output_arbiter
   import upsp_arb_pkg::*;
#(
   parameter int unsigned N_PARALLEL     = 4,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned DST_IMG_WIDTH  = 3840,
   parameter int unsigned DST_IMG_HEIGHT = 2160,
   parameter int unsigned PIX_PER_BEAT   = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic                             abort,
   input  logic [N_PARALLEL-1:0]            upsp_wvalid,
   input  logic [N_PARALLEL*DATA_WIDTH-1:0] upsp_wdata,
   output logic [N_PARALLEL-1:0]            upsp_wready,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic [DATA_WIDTH-1:0]            m_axis_tdata,
   output logic                             m_axis_tlast,
   output logic                             m_axis_tuser,
   output logic                             busy,
`ifdef UPSP_ARB_STALL_CNT_EN
   output logic [31:0]                      stall_cycles,
`endif
   output logic                             frame_done
);

   localparam int unsigned BeatsRow = DST_IMG_WIDTH / PIX_PER_BEAT;
   localparam int unsigned ColW     = cnt_width(BeatsRow);
   localparam int unsigned RowW     = cnt_width(DST_IMG_HEIGHT);
   localparam int unsigned PtrW     = cnt_width(N_PARALLEL);

   if (!cfg_ok(N_PARALLEL, DST_IMG_WIDTH, PIX_PER_BEAT)) begin : g_cfg_err
      $error("upsp_output_arbiter: invalid N_PARALLEL / PIX_PER_BEAT configuration");
   end

   arb_state_e      state_q, state_d;
   logic [PtrW-1:0] ptr_q, ptr_d;
   logic [ColW-1:0] col_q, col_d;
   logic [RowW-1:0] row_q, row_d;
   logic            done_q, done_d;

   logic out_free, capture, last_col, last_row;

   assign last_col = (col_q == ColW'(BeatsRow - 1));
   assign last_row = (row_q == RowW'(DST_IMG_HEIGHT - 1));

   // Abort suppresses the grant so the PE never sees a handshake for a discarded word.
   always_comb begin
      upsp_wready = '0;
      if (state_q == StRun && out_free && !abort) upsp_wready[ptr_q] = 1'b1;
   end

   assign capture = upsp_wvalid[ptr_q] && upsp_wready[ptr_q];

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      col_d   = col_q;
      row_d   = row_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start && !abort) begin
               state_d = StRun;
               ptr_d   = '0;
               col_d   = '0;
               row_d   = '0;
            end
         end
         StRun: begin
            if (abort) begin
               state_d = StIdle;
               ptr_d   = '0;
               col_d   = '0;
               row_d   = '0;
            end else if (capture) begin
               if (last_col) begin
                  col_d = '0;
                  ptr_d = '0;
                  if (last_row) begin
                     state_d = StFlush;
                     row_d   = '0;
                  end else begin
                     row_d = row_q + RowW'(1);
                  end
               end else begin
                  col_d = col_q + ColW'(1);
                  ptr_d = (ptr_q == PtrW'(N_PARALLEL - 1)) ? '0 : ptr_q + PtrW'(1);
               end
            end
         end
         StFlush: begin
            if (abort) begin
               state_d = StIdle;
               ptr_d   = '0;
               col_d   = '0;
               row_d   = '0;
            end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         col_q   <= '0;
         row_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         col_q   <= col_d;
         row_q   <= row_d;
         done_q  <= done_d;
      end
   end

   upsp_arb_out_slice #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_out_slice (
      .clk      (clk),
      .rst      (rst),
      .clear    (abort && state_q != StIdle),
      .load     (capture),
      .load_data(upsp_wdata[int'(ptr_q)*DATA_WIDTH +: DATA_WIDTH]),
      .load_last(last_col),
      .load_user(col_q == '0 && row_q == '0),
      .tready   (m_axis_tready),
      .tvalid   (m_axis_tvalid),
      .tdata    (m_axis_tdata),
      .tlast    (m_axis_tlast),
      .tuser    (m_axis_tuser),
      .out_free (out_free)
   );

   assign busy       = (state_q != StIdle);
   assign frame_done = done_q;

`ifdef UPSP_ARB_STALL_CNT_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (state_q == StIdle) begin
         if (start && !abort) stall_d = '0;
      end else if (m_axis_tvalid && !m_axis_tready && stall_q != 32'hFFFF_FFFF) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) stall_q <= '0;
      else     stall_q <= stall_d;
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_upsp_output_arbiter.sv
// Directed bench: an 8x2 frame on a 4-PE arbiter and a 4x2 frame on a 3-PE arbiter.
module tb_upsp_output_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // 4-PE instance, 8x2 destination
   logic         start4, abort4, tready4, tvalid4, tlast4, tuser4, busy4, done4;
   logic [3:0]   wvalid4, wready4;
   logic [127:0] wdata4;
   logic [31:0]  tdata4;
   int unsigned  seq4 [4];
   int           done_cnt4 = 0;

   // 3-PE instance, 4x2 destination
   logic         start3, abort3, tready3, tvalid3, tlast3, tuser3, busy3, done3;
   logic [2:0]   wvalid3, wready3;
   logic [95:0]  wdata3;
   logic [31:0]  tdata3;
   int unsigned  seq3 [3];

`ifdef UPSP_ARB_STALL_CNT_EN
   logic [31:0] stall4, stall3;
`endif

   upsp_output_arbiter #(
      .N_PARALLEL(4), .DATA_WIDTH(32), .DST_IMG_WIDTH(8), .DST_IMG_HEIGHT(2), .PIX_PER_BEAT(1)
   ) dut4 (
      .clk(clk), .rst(rst), .start(start4), .abort(abort4),
      .upsp_wvalid(wvalid4), .upsp_wdata(wdata4), .upsp_wready(wready4),
      .m_axis_tvalid(tvalid4), .m_axis_tready(tready4), .m_axis_tdata(tdata4),
      .m_axis_tlast(tlast4), .m_axis_tuser(tuser4), .busy(busy4),
`ifdef UPSP_ARB_STALL_CNT_EN
      .stall_cycles(stall4),
`endif
      .frame_done(done4)
   );

   upsp_output_arbiter #(
      .N_PARALLEL(3), .DATA_WIDTH(32), .DST_IMG_WIDTH(4), .DST_IMG_HEIGHT(2), .PIX_PER_BEAT(1)
   ) dut3 (
      .clk(clk), .rst(rst), .start(start3), .abort(abort3),
      .upsp_wvalid(wvalid3), .upsp_wdata(wdata3), .upsp_wready(wready3),
      .m_axis_tvalid(tvalid3), .m_axis_tready(tready3), .m_axis_tdata(tdata3),
      .m_axis_tlast(tlast3), .m_axis_tuser(tuser3), .busy(busy3),
`ifdef UPSP_ARB_STALL_CNT_EN
      .stall_cycles(stall3),
`endif
      .frame_done(done3)
   );

   // PE models: each PE offers {tag+id, running word index}, advancing on its handshake.
   always_comb begin
      for (int i = 0; i < 4; i++) wdata4[i*32 +: 32] = {8'hA0 + 8'(i), 24'(seq4[i])};
      for (int i = 0; i < 3; i++) wdata3[i*32 +: 32] = {8'hB0 + 8'(i), 24'(seq3[i])};
   end

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (start4) seq4[i] <= 0;
         else if (wvalid4[i] && wready4[i]) seq4[i] <= seq4[i] + 1;
      end
      for (int i = 0; i < 3; i++) begin
         if (start3) seq3[i] <= 0;
         else if (wvalid3[i] && wready3[i]) seq3[i] <= seq3[i] + 1;
      end
      if (done4) done_cnt4 <= done_cnt4 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Beat b of an 8x2 frame with all PEs valid: PE b%4, that PE's (b/4)-th word.
   function automatic logic [31:0] exp4(input int b);
      return {8'hA0 + 8'(b % 4), 24'(b / 4)};
   endfunction

   // Called at a negedge; waits for an accepted beat, checks it, moves to the next negedge.
   task automatic get_beat(input int sel, input string tag, input logic [31:0] ed,
                           input logic el, input logic eu);
      int n = 0;
      while (!((sel == 4) ? (tvalid4 && tready4) : (tvalid3 && tready3)) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_hs"}, 32'((sel == 4) ? (tvalid4 && tready4) : (tvalid3 && tready3)), 32'd1);
      chk({tag, "_data"}, (sel == 4) ? tdata4 : tdata3, ed);
      chk({tag, "_last"}, 32'((sel == 4) ? tlast4 : tlast3), 32'(el));
      chk({tag, "_user"}, 32'((sel == 4) ? tuser4 : tuser3), 32'(eu));
      chk({tag, "_busy"}, 32'((sel == 4) ? busy4 : busy3), 32'd1);
      @(negedge clk);
   endtask

   logic [31:0] exp3 [8];

   initial begin
      exp3 = '{32'hB000_0000, 32'hB100_0000, 32'hB200_0000, 32'hB000_0001,
               32'hB000_0002, 32'hB100_0001, 32'hB200_0001, 32'hB000_0003};
      rst = 1'b1;
      start4 = 1'b0; abort4 = 1'b0; wvalid4 = '0; tready4 = 1'b0;
      start3 = 1'b0; abort3 = 1'b0; wvalid3 = '0; tready3 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_tvalid4", 32'(tvalid4), 32'd0);
      chk("rst_wready4", 32'(wready4), 32'd0);
      chk("rst_busy4", 32'(busy4), 32'd0);
      chk("rst_done4", 32'(done4), 32'd0);
      chk("rst_tvalid3", 32'(tvalid3), 32'd0);
`ifdef UPSP_ARB_STALL_CNT_EN
      chk("rst_stall4", stall4, 32'd0);
`endif

      // Frame 1: free-flowing 8x2 frame
      wvalid4 = 4'hF; tready4 = 1'b1; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      chk("f1_busy", 32'(busy4), 32'd1);
      for (int b = 0; b < 16; b++)
         get_beat(4, $sformatf("f1_b%0d", b), exp4(b), (b % 8) == 7, b == 0);
      chk("f1_done", 32'(done4), 32'd1);
      chk("f1_busy_end", 32'(busy4), 32'd0);
      @(negedge clk);
      chk("f1_done_pulse", 32'(done4), 32'd0);
      chk("f1_done_cnt", 32'(done_cnt4), 32'd1);

      // Frame 2: downstream stall for 5 cycles while beat 3 is presented
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      for (int b = 0; b < 3; b++)
         get_beat(4, $sformatf("f2_b%0d", b), exp4(b), 1'b0, b == 0);
      tready4 = 1'b0;
      #1;
      chk("f2_stall_data0", tdata4, exp4(3));
      chk("f2_stall_wready0", 32'(wready4), 32'd0);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         chk($sformatf("f2_stall_data%0d", i), tdata4, exp4(3));
         chk($sformatf("f2_stall_valid%0d", i), 32'(tvalid4), 32'd1);
         chk($sformatf("f2_stall_wready%0d", i), 32'(wready4), 32'd0);
      end
      tready4 = 1'b1;
      for (int b = 3; b < 16; b++)
         get_beat(4, $sformatf("f2_b%0d", b), exp4(b), (b % 8) == 7, 1'b0);
      chk("f2_done", 32'(done4), 32'd1);
`ifdef UPSP_ARB_STALL_CNT_EN
      chk("f2_stall_cycles", stall4, 32'd5);
`endif
      @(negedge clk);

      // Frame 3: out-of-turn valid, then abort while beat 5 is presented
      wvalid4 = 4'b0100;
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
`ifdef UPSP_ARB_STALL_CNT_EN
      chk("f3_stall_clr", stall4, 32'd0);
`endif
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("f3_oot_wready%0d", i), 32'(wready4), 32'h1);
         chk($sformatf("f3_oot_tvalid%0d", i), 32'(tvalid4), 32'd0);
         @(negedge clk);
      end
      wvalid4 = 4'hF;
      for (int b = 0; b < 5; b++)
         get_beat(4, $sformatf("f3_b%0d", b), exp4(b), 1'b0, b == 0);
      chk("f3_b5_data", tdata4, exp4(5));
      abort4 = 1'b1;
      @(negedge clk);
      abort4 = 1'b0;
      chk("f3_abort_tvalid", 32'(tvalid4), 32'd0);
      chk("f3_abort_busy", 32'(busy4), 32'd0);
      chk("f3_abort_wready", 32'(wready4), 32'd0);
      repeat (3) begin
         chk("f3_abort_nodone", 32'(done4), 32'd0);
         @(negedge clk);
      end
      chk("f3_done_cnt", 32'(done_cnt4), 32'd2);

      // Frame 4: restart after abort begins at row 0 with tuser
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      for (int b = 0; b < 16; b++)
         get_beat(4, $sformatf("f4_b%0d", b), exp4(b), (b % 8) == 7, b == 0);
      chk("f4_done", 32'(done4), 32'd1);
      @(negedge clk);
      chk("f4_done_cnt", 32'(done_cnt4), 32'd3);

      // 3-PE instance: each row restarts at PE0
      wvalid3 = 3'h7; tready3 = 1'b1; start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      chk("r3_busy", 32'(busy3), 32'd1);
      for (int b = 0; b < 8; b++)
         get_beat(3, $sformatf("r3_b%0d", b), exp3[b], (b % 4) == 3, b == 0);
      chk("r3_done", 32'(done3), 32'd1);
      chk("r3_busy_end", 32'(busy3), 32'd0);
      @(negedge clk);
      chk("r3_done_pulse", 32'(done3), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
